clk_rst_seq: RTL and testbench

// - Sequencer that drives the clock/reset generator: programs the 3 PLL dividers, waits for lock,

---
 rtl/clk_rst_seq_if.sv | 20 ++
 rtl/clk_rst_seq.sv | 233 +++++++++++++++++++++++
 tb/tb_clk_rst_seq.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/clk_rst_seq_if.sv
// Reprogramming request port of the clock/reset sequencer.
// The master side issues PLL divider updates; the sequencer is the slave.
interface clk_rst_seq_if;
  logic        cfg_valid_i;
  logic        cfg_ready_o;
  logic [1:0]  cfg_pll_sel_i;
  logic [3:0]  cfg_ref_div_i;
  logic [11:0] cfg_fb_div_i;
  logic        cfg_err_o;

  modport master (
    output cfg_valid_i, cfg_pll_sel_i, cfg_ref_div_i, cfg_fb_div_i,
    input  cfg_ready_o, cfg_err_o
  );

  modport slave (
    input  cfg_valid_i, cfg_pll_sel_i, cfg_ref_div_i, cfg_fb_div_i,
    output cfg_ready_o, cfg_err_o
  );
endinterface

// File: rtl/clk_rst_seq.sv
// Clock/reset generator sequencer: boots the 3 PLLs, enables the 5 domain
// clocks and releases their resets; quiesces affected domains around a
// runtime PLL reprogram.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// BOOT_LOCK | after reset: wait for all three PLLs locked
// CLK_ON    | clock enables of target set raised, settling
// REL       | releasing target resets SL, PL, CL, P, E, RST_GAP apart
// RUN       | sequence complete, accepting reprogram requests
// Q_RST     | target resets asserted, waiting RST_GAP
// Q_GATE    | target clocks gated, waiting CLK_SETTLE
// PROG      | new dividers on the selected PLL
// LOCK      | blanking, then waiting for the selected PLL lock
// ERR       | lock timeout, frozen until reset
module clk_rst_seq #(
  parameter int         LOCK_TIMEOUT = 4096,
  parameter int         CLK_SETTLE   = 8,
  parameter int         RST_GAP      = 16,
  parameter logic [3:0] DEF_REF_DIV  = 4'd1,
  parameter logic [11:0] DEF_FB_DIV  = 12'd40
) (
  input  logic         ref_clk_i,
  input  logic         srst_i,
  output logic [11:0]  pll_ref_div_o,
  output logic [35:0]  pll_fb_div_o,
  input  logic [2:0]   pll_locked_i,
  output logic [4:0]   clk_en_o,
  output logic [4:0]   arst_no,
  output logic         seq_done_o,
  output logic         lock_err_o,
  clk_rst_seq_if.slave cfg
);

  localparam int MAX_A = (LOCK_TIMEOUT > RST_GAP) ? LOCK_TIMEOUT : RST_GAP;
  localparam int MAX_P = (MAX_A > CLK_SETTLE) ? MAX_A : CLK_SETTLE;
  localparam int CW    = $clog2(MAX_P + 1);

  localparam logic [CW-1:0] TO_LAST     = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(CLK_SETTLE - 1);
  localparam logic [CW-1:0] SETTLE_CNT  = CW'(CLK_SETTLE);
  localparam logic [CW-1:0] GAP_LAST    = CW'(RST_GAP - 1);

  typedef enum logic [3:0] {
    BOOT_LOCK, CLK_ON, REL, RUN, Q_RST, Q_GATE, PROG, LOCK, ERR
  } state_t;

  state_t       state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [4:0]   tgt, tgt_d;
  logic [1:0]   sel, sel_d;
  logic [3:0]   nref, nref_d;
  logic [11:0]  nfb, nfb_d;
  logic [2:0]   lk_meta, lk_sync;
  logic [4:0]   clk_en_q, clk_en_d;
  logic [4:0]   arst_n_q, arst_n_d;
  logic [11:0]  ref_q, ref_d;
  logic [35:0]  fb_q, fb_d;
  logic         cfg_err_q, cfg_err_d;
  logic         lock_err_q, lock_err_d;
  logic [4:0]   rem;
  logic [3:0]   lk_ext;
  logic         cfg_bad;

  // Next reset to release: SL first, then PL, CL, P, E.
  function automatic logic [4:0] first_rel(input logic [4:0] r);
    if      (r[3]) return 5'b01000;
    else if (r[4]) return 5'b10000;
    else if (r[2]) return 5'b00100;
    else if (r[1]) return 5'b00010;
    else if (r[0]) return 5'b00001;
    else           return 5'b00000;
  endfunction

  // Domains fed by each PLL; CL is never part of a reprogram.
  function automatic logic [4:0] tgt_of(input logic [1:0] s);
    case (s)
      2'd0:    return 5'b00001;
      2'd1:    return 5'b00010;
      default: return 5'b11000;
    endcase
  endfunction

  assign rem     = tgt & ~arst_n_q;
  assign lk_ext  = {1'b0, lk_sync};
  assign cfg_bad = (cfg.cfg_pll_sel_i == 2'd3) || (cfg.cfg_ref_div_i == 4'd0) ||
                   (cfg.cfg_fb_div_i == 12'd0);

  // Two-flop synchroniser for the asynchronous PLL lock inputs.
  always_ff @(posedge ref_clk_i) begin
    if (srst_i) begin
      lk_meta <= 3'b000;
      lk_sync <= 3'b000;
    end else begin
      lk_meta <= pll_locked_i;
      lk_sync <= lk_meta;
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge ref_clk_i) begin
    if (srst_i) begin
      state      <= BOOT_LOCK;
      cnt        <= '0;
      tgt        <= 5'b11111;
      sel        <= 2'd0;
      nref       <= 4'd0;
      nfb        <= 12'd0;
      clk_en_q   <= 5'b00000;
      arst_n_q   <= 5'b00000;
      ref_q      <= {3{DEF_REF_DIV}};
      fb_q       <= {3{DEF_FB_DIV}};
      cfg_err_q  <= 1'b0;
      lock_err_q <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      tgt        <= tgt_d;
      sel        <= sel_d;
      nref       <= nref_d;
      nfb        <= nfb_d;
      clk_en_q   <= clk_en_d;
      arst_n_q   <= arst_n_d;
      ref_q      <= ref_d;
      fb_q       <= fb_d;
      cfg_err_q  <= cfg_err_d;
      lock_err_q <= lock_err_d;
    end
  end

  // Sequencing decisions; output changes are made on the edge entering a state.
  always_comb begin
    state_d    = state;
    cnt_d      = (cnt == '1) ? cnt : cnt + 1'b1;
    tgt_d      = tgt;
    sel_d      = sel;
    nref_d     = nref;
    nfb_d      = nfb;
    clk_en_d   = clk_en_q;
    arst_n_d   = arst_n_q;
    ref_d      = ref_q;
    fb_d       = fb_q;
    cfg_err_d  = 1'b0;
    lock_err_d = lock_err_q;
    case (state)
      BOOT_LOCK: begin
        if (&lk_sync) begin
          state_d  = CLK_ON;
          cnt_d    = '0;
          clk_en_d = clk_en_q | tgt;
        end else if (cnt >= TO_LAST) begin
          state_d    = ERR;
          lock_err_d = 1'b1;
        end
      end
      CLK_ON: begin
        if (cnt >= SETTLE_LAST) begin
          state_d  = REL;
          cnt_d    = '0;
          arst_n_d = arst_n_q | first_rel(rem);
        end
      end
      REL: begin
        if (rem == 5'b00000) begin
          state_d = RUN;
        end else if (cnt >= GAP_LAST) begin
          cnt_d    = '0;
          arst_n_d = arst_n_q | first_rel(rem);
        end
      end
      RUN: begin
        if (cfg.cfg_valid_i) begin
          if (cfg_bad) begin
            cfg_err_d = 1'b1;
          end else begin
            state_d  = Q_RST;
            cnt_d    = '0;
            sel_d    = cfg.cfg_pll_sel_i;
            nref_d   = cfg.cfg_ref_div_i;
            nfb_d    = cfg.cfg_fb_div_i;
            tgt_d    = tgt_of(cfg.cfg_pll_sel_i);
            arst_n_d = arst_n_q & ~tgt_of(cfg.cfg_pll_sel_i);
          end
        end
      end
      Q_RST: begin
        if (cnt >= GAP_LAST) begin
          state_d  = Q_GATE;
          cnt_d    = '0;
          clk_en_d = clk_en_q & ~tgt;
        end
      end
      Q_GATE: begin
        if (cnt >= SETTLE_LAST) begin
          state_d = PROG;
          cnt_d   = '0;
          case (sel)
            2'd0:    begin ref_d[3:0]  = nref; fb_d[11:0]  = nfb; end
            2'd1:    begin ref_d[7:4]  = nref; fb_d[23:12] = nfb; end
            default: begin ref_d[11:8] = nref; fb_d[35:24] = nfb; end
          endcase
        end
      end
      PROG: begin
        state_d = LOCK;
        cnt_d   = '0;
      end
      LOCK: begin
        if ((cnt >= SETTLE_CNT) && lk_ext[sel]) begin
          state_d  = CLK_ON;
          cnt_d    = '0;
          clk_en_d = clk_en_q | tgt;
        end else if (cnt >= TO_LAST) begin
          state_d    = ERR;
          lock_err_d = 1'b1;
        end
      end
      default: begin
        state_d = state;
      end
    endcase
  end

  assign pll_ref_div_o   = ref_q;
  assign pll_fb_div_o    = fb_q;
  assign clk_en_o        = clk_en_q;
  assign arst_no         = arst_n_q;
  assign seq_done_o      = (state == RUN);
  assign lock_err_o      = lock_err_q;
  assign cfg.cfg_ready_o = (state == RUN);
  assign cfg.cfg_err_o   = cfg_err_q;

endmodule

// File: tb/tb_clk_rst_seq.sv
// Bench for clk_rst_seq: boot, invalid requests, reprograms with random
// dividers and lock timing, reset during lock wait, and boot lock timeout.
module tb_clk_rst_seq;
  localparam int LOCK_TIMEOUT = 4096;
  localparam int CLK_SETTLE   = 8;
  localparam int RST_GAP      = 16;

  logic        clk = 1'b0;
  logic        srst;
  logic [2:0]  locked;
  logic [11:0] ref_div;
  logic [35:0] fb_div;
  logic [4:0]  clk_en;
  logic [4:0]  arst_n;
  logic        seq_done;
  logic        lock_err;

  clk_rst_seq_if cfg_if ();

  clk_rst_seq dut (
    .ref_clk_i     (clk),
    .srst_i        (srst),
    .pll_ref_div_o (ref_div),
    .pll_fb_div_o  (fb_div),
    .pll_locked_i  (locked),
    .clk_en_o      (clk_en),
    .arst_no       (arst_n),
    .seq_done_o    (seq_done),
    .lock_err_o    (lock_err),
    .cfg           (cfg_if)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int order[5] = '{3, 4, 2, 1, 0};
  logic [3:0]  m_ref[3];
  logic [11:0] m_fb[3];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  function automatic logic [11:0] exp_ref();
    return {m_ref[2], m_ref[1], m_ref[0]};
  endfunction

  function automatic logic [35:0] exp_fb();
    return {m_fb[2], m_fb[1], m_fb[0]};
  endfunction

  function automatic logic [4:0] domains_of(input int s);
    case (s)
      0:       return 5'b00001;
      1:       return 5'b00010;
      default: return 5'b11000;
    endcase
  endfunction

  task automatic do_reset(input int n);
    srst = 1'b1;
    locked = 3'b000;
    cfg_if.cfg_valid_i = 1'b0;
    for (int i = 0; i < n; i++) tick();
    for (int p = 0; p < 3; p++) begin
      m_ref[p] = 4'd1;
      m_fb[p]  = 12'd40;
    end
    chk("rst_clk_en", clk_en, 5'h00);
    chk("rst_arst_n", arst_n, 5'h00);
    chk("rst_ref_div", ref_div, exp_ref());
    chk("rst_fb_div", fb_div, exp_fb());
    chk("rst_ready", cfg_if.cfg_ready_o, 1'b0);
    chk("rst_cfg_err", cfg_if.cfg_err_o, 1'b0);
    chk("rst_done", seq_done, 1'b0);
    chk("rst_lock_err", lock_err, 1'b0);
    srst = 1'b0;
  endtask

  // Releases appear in SL, PL, CL, P, E order, first CLK_SETTLE after the
  // clock enable, then RST_GAP apart; only target bits change.
  task automatic check_release(input logic [4:0] tgt, input logic [4:0] base, input int t_en);
    logic [4:0] cum;
    int k;
    cum = 5'b00000;
    k = 0;
    for (int j = 0; j < 5; j++) begin
      if (tgt[order[j]]) begin
        for (int i = 0; i < 200 && !arst_n[order[j]]; i++) tick();
        chk($sformatf("rel_time_b%0d", order[j]), cyc - t_en, CLK_SETTLE + RST_GAP * k);
        cum[order[j]] = 1'b1;
        chk($sformatf("rel_mask_b%0d", order[j]), arst_n, base | cum);
        k++;
      end
    end
    for (int i = 0; i < 5 && !seq_done; i++) tick();
    chk("seq_done", seq_done, 1'b1);
    chk("cfg_ready", cfg_if.cfg_ready_o, 1'b1);
  endtask

  task automatic boot(input int delay);
    int t_en;
    for (int i = 0; i < delay; i++) tick();
    locked = 3'b111;
    for (int i = 0; i < 300 && clk_en == 5'h00; i++) tick();
    chk("boot_clk_en", clk_en, 5'h1F);
    chk("boot_arst_pre", arst_n, 5'h00);
    t_en = cyc;
    check_release(5'h1F, 5'h00, t_en);
  endtask

  task automatic invalid_req(input string tag, input int s, input int r, input int f);
    logic [4:0]  s_en, s_rst;
    logic [11:0] s_ref;
    logic [35:0] s_fb;
    s_en = clk_en; s_rst = arst_n; s_ref = ref_div; s_fb = fb_div;
    chk({tag, "_ready"}, cfg_if.cfg_ready_o, 1'b1);
    cfg_if.cfg_valid_i   = 1'b1;
    cfg_if.cfg_pll_sel_i = 2'(s);
    cfg_if.cfg_ref_div_i = 4'(r);
    cfg_if.cfg_fb_div_i  = 12'(f);
    tick();
    cfg_if.cfg_valid_i = 1'b0;
    chk({tag, "_err_pulse"}, cfg_if.cfg_err_o, 1'b1);
    tick();
    chk({tag, "_err_end"}, cfg_if.cfg_err_o, 1'b0);
    chk({tag, "_done"}, seq_done, 1'b1);
    chk({tag, "_outs"}, {clk_en, arst_n, ref_div, fb_div}, {s_en, s_rst, s_ref, s_fb});
  endtask

  // Issues a valid request and follows it up to the programmed dividers;
  // returns the cycle at which the handshake took effect.
  task automatic start_reconfig(input int s, input int r, input int f, output int h);
    logic [4:0] tgt, s_en, s_rst;
    tgt = domains_of(s);
    s_en = clk_en; s_rst = arst_n;
    chk("rc_ready", cfg_if.cfg_ready_o, 1'b1);
    cfg_if.cfg_valid_i   = 1'b1;
    cfg_if.cfg_pll_sel_i = 2'(s);
    cfg_if.cfg_ref_div_i = 4'(r);
    cfg_if.cfg_fb_div_i  = 12'(f);
    tick();
    cfg_if.cfg_valid_i = 1'b0;
    h = cyc;
    chk("rc_rst_assert", arst_n, s_rst & ~tgt);
    chk("rc_done_drop", {seq_done, cfg_if.cfg_ready_o}, 2'b00);
    chk("rc_clk_hold", clk_en, s_en);
    for (int i = 0; i < 100 && (clk_en & tgt) != 5'h00; i++) tick();
    chk("rc_gate_time", cyc - h, RST_GAP);
    chk("rc_gate_mask", clk_en, s_en & ~tgt);
    while (cyc < h + RST_GAP + CLK_SETTLE - 1) tick();
    chk("rc_div_pre", {ref_div, fb_div}, {exp_ref(), exp_fb()});
    tick();
    m_ref[s] = 4'(r);
    m_fb[s]  = 12'(f);
    chk("rc_div_new", {ref_div, fb_div}, {exp_ref(), exp_fb()});
    locked[s] = 1'b0;
  endtask

  task automatic reconfig(input int s, input int r, input int f, input bit glitch);
    logic [4:0] tgt, s_en, s_rst;
    int h, d, t_l, t_en;
    tgt = domains_of(s);
    s_en = clk_en; s_rst = arst_n;
    start_reconfig(s, r, f, h);
    if (glitch) begin
      tick(); tick();
      locked[s] = 1'b1;
      tick(); tick();
      locked[s] = 1'b0;
    end
    d = $urandom_range(40, 15);
    while (cyc < h + RST_GAP + CLK_SETTLE + d) tick();
    locked[s] = 1'b1;
    t_l = cyc;
    for (int i = 0; i < 200 && (clk_en & tgt) == 5'h00; i++) tick();
    chk("rc_relock_time", cyc - t_l, 3);
    chk("rc_clk_back", clk_en, s_en);
    chk("rc_rst_held", arst_n, s_rst & ~tgt);
    t_en = cyc;
    check_release(tgt, s_rst & ~tgt, t_en);
    chk("rc_div_final", {ref_div, fb_div}, {exp_ref(), exp_fb()});
  endtask

  initial begin
    int h, s, r0;
    srst = 1'b1;
    locked = 3'b000;
    cfg_if.cfg_valid_i   = 1'b0;
    cfg_if.cfg_pll_sel_i = 2'd0;
    cfg_if.cfg_ref_div_i = 4'd0;
    cfg_if.cfg_fb_div_i  = 12'd0;

    do_reset(3);
    boot(100);

    invalid_req("inv_sel", 3, $urandom_range(15, 1), $urandom_range(4095, 1));
    invalid_req("inv_fb", $urandom_range(2, 0), $urandom_range(15, 1), 0);
    invalid_req("inv_ref", $urandom_range(2, 0), 0, $urandom_range(4095, 1));

    reconfig(2, 2, 60, 1'b0);
    reconfig(2, $urandom_range(15, 1), $urandom_range(4095, 1), 1'b1);
    for (int n = 0; n < 4; n++)
      reconfig($urandom_range(2, 0), $urandom_range(15, 1), $urandom_range(4095, 1),
               1'($urandom_range(1, 0)));

    s = $urandom_range(2, 0);
    start_reconfig(s, $urandom_range(15, 1), $urandom_range(4095, 1), h);
    for (int i = 0; i < 4; i++) tick();
    do_reset(1);
    boot($urandom_range(200, 20));

    do_reset(2);
    r0 = cyc;
    for (int i = 0; i < LOCK_TIMEOUT + 50 && !lock_err; i++) tick();
    chk("to_cycle", cyc - r0, LOCK_TIMEOUT);
    chk("to_flag", lock_err, 1'b1);
    chk("to_outs", {clk_en, arst_n, seq_done, cfg_if.cfg_ready_o}, 12'h000);
    locked = 3'b111;
    for (int i = 0; i < 20; i++) tick();
    chk("to_sticky", {lock_err, clk_en}, {1'b1, 5'h00});
    do_reset(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got time-limit expected finish");
    $fatal(1, "watchdog");
  end
endmodule
